// File: rtl/sync_dp_mem_if.sv
// Request/response bundle for the two-port synchronous memory.
// Port A is read-only; port B can read and/or write each cycle.
interface sync_dp_mem_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
);
  logic              ready;
  logic [ADDR_W-1:0] a_addr;
  logic              a_rd;
  logic [DATA_W-1:0] a_dout;
  logic              a_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic              b_rd;
  logic              b_wr;
  logic [DATA_W-1:0] b_dout;
  logic              b_valid;

  modport master (
    input  ready, a_dout, a_valid, b_dout, b_valid,
    output a_addr, a_rd, b_addr, b_din, b_rd, b_wr
  );

  modport slave (
    input  a_addr, a_rd, b_addr, b_din, b_rd, b_wr,
    output ready, a_dout, a_valid, b_dout, b_valid
  );
endinterface

// File: rtl/sync_dp_mem.sv
// Synchronous two-port memory with registered reads and a post-reset
// init sweep that loads INIT_VAL into every word before accepting requests.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | sweeping INIT_VAL into mem[init_ptr]; all requests ignored
//   RUN   | sweep complete, ready=1; port A/B requests accepted
module sync_dp_mem #(
  parameter int                 DATA_W   = 10,
  parameter int                 ADDR_W   = 4,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  sync_dp_mem_if.slave bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic running;
  logic a_acc;
  logic b_rd_acc;
  logic b_wr_acc;
  logic a_fwd;

  assign running  = (state == ST_RUN);
  assign a_acc    = running & bus.a_rd;
  assign b_rd_acc = running & bus.b_rd;
  assign b_wr_acc = running & bus.b_wr;
  // Same-cycle port B write to the address port A is reading: A sees new data.
  assign a_fwd    = b_wr_acc & (bus.b_addr == bus.a_addr);

  // ready rises on the same edge that writes the last sweep word.
  assign bus.ready = running;

  // Init sequencer: one word per clock, then park in RUN until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else if (state == ST_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == LAST_PTR) begin
        state <= ST_RUN;
      end
    end
  end

  // Array write path; contents are never touched by the async reset itself.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_ptr] <= INIT_VAL;
    end else if (b_wr_acc) begin
      mem[bus.b_addr] <= bus.b_din;
    end
  end

  // Port A registered read with write-first forwarding from port B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.a_valid <= 1'b0;
      bus.a_dout  <= '0;
    end else begin
      bus.a_valid <= a_acc;
      if (a_acc) begin
        bus.a_dout <= a_fwd ? bus.b_din : mem[bus.a_addr];
      end
    end
  end

  // Port B registered read; a combined read+write returns the written data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.b_valid <= 1'b0;
      bus.b_dout  <= '0;
    end else begin
      bus.b_valid <= b_rd_acc;
      if (b_rd_acc) begin
        bus.b_dout <= b_wr_acc ? bus.b_din : mem[bus.b_addr];
      end
    end
  end

`ifdef SIM
  // Simulation-only access trace.
  always @(posedge clk) begin
    if (!reset && running) begin
      if (a_acc)    $display("%t sync_dp_mem A rd [%0d]", $time, bus.a_addr);
      if (b_wr_acc) $display("%t sync_dp_mem B wr [%0d] <= %h", $time, bus.b_addr, bus.b_din);
      if (b_rd_acc) $display("%t sync_dp_mem B rd [%0d]", $time, bus.b_addr);
    end
  end
`endif

endmodule

// File: tb/tb_sync_dp_mem.sv
// Randomised scoreboard bench for sync_dp_mem: a driver predicts each response
// from a plain array model and queues it; a monitor pops and compares whenever
// a valid strobe appears. A second instance covers the 64x32 configuration.
module tb_sync_dp_mem;
  localparam int              DW    = 10;
  localparam int              AW    = 4;
  localparam int              DEPTH = 16;
  localparam logic [DW-1:0]   IV    = '0;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset2 = 1'b1;

  always #5 clk = ~clk;

  sync_dp_mem_if #(.DATA_W(DW), .ADDR_W(AW)) m1 ();
  sync_dp_mem #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(IV)) dut (
    .clk(clk), .reset(reset), .bus(m1.slave)
  );

  sync_dp_mem_if #(.DATA_W(32), .ADDR_W(6)) m2 ();
  sync_dp_mem #(.DATA_W(32), .ADDR_W(6), .INIT_VAL(32'hDEADBEEF)) dut2 (
    .clk(clk), .reset(reset2), .bus(m2.slave)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            issue;
  } exp_t;

  int            vectors     = 0;
  int            miscompares = 0;
  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  int            cyc = 0;
  int            mdl_edges = 0;
  bit            done2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: advance the sweep model, then check outputs 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    if (!reset && mdl_edges < DEPTH) mdl_edges++;
    cyc++;
    #1;
    chk("ready", m1.ready, mdl_edges >= DEPTH);
    if (mdl_edges < DEPTH) begin
      chk("a_valid_init", m1.a_valid, 0);
      chk("b_valid_init", m1.b_valid, 0);
      chk("a_dout_init", m1.a_dout, 0);
      chk("b_dout_init", m1.b_dout, 0);
    end
    if (m1.a_valid) begin
      if (qa.size() == 0) chk("a_valid_spurious", m1.a_valid, 0);
      else begin
        e = qa.pop_front();
        chk("a_dout", m1.a_dout, e.data);
        chk("a_latency", cyc, e.issue + 1);
        last_a = e.data;
      end
    end else begin
      if (qa.size() > 0 && qa[0].issue + 1 <= cyc) begin
        chk("a_valid_missing", m1.a_valid, 1);
        void'(qa.pop_front());
      end
      if (m1.ready) chk("a_dout_hold", m1.a_dout, last_a);
    end
    if (m1.b_valid) begin
      if (qb.size() == 0) chk("b_valid_spurious", m1.b_valid, 0);
      else begin
        e = qb.pop_front();
        chk("b_dout", m1.b_dout, e.data);
        chk("b_latency", cyc, e.issue + 1);
        last_b = e.data;
      end
    end else begin
      if (qb.size() > 0 && qb[0].issue + 1 <= cyc) begin
        chk("b_valid_missing", m1.b_valid, 1);
        void'(qb.pop_front());
      end
      if (m1.ready) chk("b_dout_hold", m1.b_dout, last_b);
    end
  end

  // Driver: apply one cycle of requests and queue the model's expected responses.
  task automatic drive(input bit ard, input logic [AW-1:0] aa, input bit brd,
                       input bit bwr, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    exp_t e;
    @(negedge clk);
    m1.a_rd = ard; m1.a_addr = aa; m1.b_rd = brd; m1.b_wr = bwr;
    m1.b_addr = ba; m1.b_din = bd;
    if (mdl_edges >= DEPTH) begin
      if (ard) begin
        e.data = (bwr && ba == aa) ? bd : mdl[aa];
        e.issue = cyc;
        qa.push_back(e);
      end
      if (brd) begin
        e.data = bwr ? bd : mdl[ba];
        e.issue = cyc;
        qb.push_back(e);
      end
      if (bwr) mdl[ba] = bd;
    end
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, '0);
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    reset = 1'b1;
    mdl_edges = 0;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    m1.a_rd = 0; m1.b_rd = 0; m1.b_wr = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = IV;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_sweep(input int target);
    int n;
    n = 0;
    while (mdl_edges < target && n < 100) begin
      idle();
      n++;
    end
    if (mdl_edges < target) chk("sweep_timeout", mdl_edges, target);
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
            AW'($urandom), DW'($urandom));
    end
  endtask

  // Second configuration: 64-word sweep length and INIT_VAL readback.
  initial begin
    int n;
    m2.a_rd = 0; m2.a_addr = '0; m2.b_rd = 0; m2.b_wr = 0; m2.b_addr = '0; m2.b_din = '0;
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
    n = 0;
    while (!m2.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep64_len", n, 64);
    @(negedge clk);
    m2.a_rd = 1; m2.a_addr = 6'd63; m2.b_rd = 1; m2.b_addr = 6'd0;
    @(posedge clk); #1;
    chk("w32_a_valid", m2.a_valid, 1);
    chk("w32_a_dout63", m2.a_dout, 32'hDEADBEEF);
    chk("w32_b_valid", m2.b_valid, 1);
    chk("w32_b_dout0", m2.b_dout, 32'hDEADBEEF);
    @(negedge clk);
    m2.a_rd = 0; m2.b_rd = 0;
    @(posedge clk); #1;
    chk("w32_a_valid_drop", m2.a_valid, 0);
    done2 = 1'b1;
  end

  initial begin
    int n;
    m1.a_rd = 0; m1.a_addr = '0; m1.b_rd = 0; m1.b_wr = 0; m1.b_addr = '0; m1.b_din = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = IV;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Requests during INIT are ignored.
    wait_sweep(3);
    drive(1, 4'd2, 1, 1, 4'd2, 10'h3FF);
    idle();
    // Reset pulsed part-way through the sweep restarts it from zero.
    wait_sweep(8);
    pulse_reset(1);
    wait_sweep(DEPTH);

    drive(1, 4'd5, 0, 0, 4'd0, 10'h000);
    drive(0, 4'd0, 1, 0, 4'd15, 10'h000);
    drive(0, 4'd0, 0, 1, 4'd3, 10'h174);
    drive(0, 4'd0, 1, 0, 4'd3, 10'h000);
    drive(1, 4'd7, 0, 1, 4'd7, 10'h2AA);
    drive(0, 4'd0, 1, 1, 4'd9, 10'h011);
    drive(1, 4'd2, 1, 0, 4'd2, 10'h000);
    drive(1, 4'd7, 1, 0, 4'd9, 10'h000);
    idle();

    random_traffic(400);
    idle(); idle();

    // Reset while running reinitialises the whole array.
    pulse_reset(2);
    wait_sweep(DEPTH);
    random_traffic(150);
    idle(); idle(); idle();

    n = 0;
    while (!done2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("cfg64_done", done2, 1);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
